dmem_ctrl: RTL and testbench

Parametrised, byte-addressed, big-endian data memory with a request/done handshake, configurable access latency, byte/half/word sizes with optional sign extension, and error signalling. It replaces the single-cycle data memory in the datapath's MEM stage: the stage issues one request, holds `busy`-aware, and consumes `rdata` on the `done` pulse. The storage array stays hierarchically loadable by benches.

---
 rtl/dmem_ctrl_if.sv | 24 ++
 rtl/dmem_ctrl.sv | 143 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/completion bus between the MEM stage and dmem_ctrl.
// Vectors use ascending bit numbering: bit 0 is the MSB, bit 31 the LSB.
interface dmem_ctrl_if;
  logic        req;
  logic        wr;
  logic [0:31] addr;
  logic [0:1]  dsize;
  logic        sext;
  logic [0:31] wdata;
  logic        busy;
  logic        done;
  logic [0:31] rdata;
  logic        err;

  modport master (
    output req, wr, addr, dsize, sext, wdata,
    input  busy, done, rdata, err
  );

  modport slave (
    input  req, wr, addr, dsize, sext, wdata,
    output busy, done, rdata, err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Big-endian byte-addressed data memory with a fixed-latency request/done handshake,
// byte/half/word accesses, optional sign extension and illegal-access error pulses.
module dmem_ctrl #(
  parameter int unsigned SIZE    = 8192,
  parameter int unsigned LATENCY = 1
) (
  input logic        clk,
  input logic        reset,
  dmem_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(SIZE);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [2:0]  cnt;
  logic        l_wr, l_sext;
  logic [0:31] l_addr, l_wdata;
  logic [0:1]  l_dsize;

  logic [0:7]  mem [0:SIZE-1];

  logic          accept, finish, illegal;
  logic [2:0]    nbytes;
  logic [32:0]   span;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [0:31]   ldval;
  logic          done_n, err_n, done_q, err_q;
  logic [0:31]   rdata_n, rdata_q;

  assign accept = (state == IDLE) && bus.req;
  assign finish = (state == WAIT) && (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.req)     state_n = WAIT;
      WAIT:    if (cnt == '0)   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request fields are captured at accept so the requester may move on immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      l_wr    <= 1'b0;
      l_sext  <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_dsize <= '0;
    end else if (accept) begin
      cnt     <= 3'(LATENCY - 1);
      l_wr    <= bus.wr;
      l_sext  <= bus.sext;
      l_addr  <= bus.addr;
      l_wdata <= bus.wdata;
      l_dsize <= bus.dsize;
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - 3'd1;
    end
  end

  always_comb begin
    case (l_dsize)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    // 33-bit sum keeps addresses near 2^32 from wrapping into range.
    span    = {1'b0, l_addr} + {30'b0, nbytes};
    illegal = (l_dsize == 2'b11)
           || ((l_dsize == 2'b01) && l_addr[31])
           || ((l_dsize == 2'b10) && (l_addr[30:31] != 2'b00))
           || (span > 33'(SIZE));
  end

  always_comb begin
    a0 = l_addr[32-AW:31];
    a1 = a0 + AW'(1);
    a2 = a0 + AW'(2);
    a3 = a0 + AW'(3);
    case (l_dsize)
      2'b00:   ldval = {{24{l_sext & mem[a0][0]}}, mem[a0]};
      2'b01:   ldval = {{16{l_sext & mem[a0][0]}}, mem[a0], mem[a1]};
      default: ldval = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  always_comb begin
    done_n  = finish;
    err_n   = finish && illegal;
    rdata_n = rdata_q;
    if (finish && !illegal && !l_wr) rdata_n = ldval;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q  <= done_n;
      err_q   <= err_n;
      rdata_q <= rdata_n;
    end
  end

  // Storage is deliberately not reset so preloaded contents survive reset.
  always_ff @(posedge clk) begin
    if (finish && !illegal && l_wr) begin
      case (l_dsize)
        2'b00: mem[a0] <= l_wdata[24:31];
        2'b01: begin
          mem[a0] <= l_wdata[16:23];
          mem[a1] <= l_wdata[24:31];
        end
        2'b10: begin
          mem[a0] <= l_wdata[0:7];
          mem[a1] <= l_wdata[8:15];
          mem[a2] <= l_wdata[16:23];
          mem[a3] <= l_wdata[24:31];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state == WAIT);
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (LATENCY 1 / 4) checked against a byte-array
// reference model with directed and randomized requests.
module tb_dmem_ctrl;

  localparam int unsigned SZA = 8192;
  localparam int unsigned SZB = 128;
  localparam int          LTA = 1;
  localparam int          LTB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  dmem_ctrl_if a_if();
  dmem_ctrl_if b_if();

  dmem_ctrl #(.SIZE(SZA), .LATENCY(LTA)) dut_a (.clk(clk), .reset(rst_a), .bus(a_if.slave));
  dmem_ctrl #(.SIZE(SZB), .LATENCY(LTB)) dut_b (.clk(clk), .reset(rst_b), .bus(b_if.slave));

  int total = 0;
  int bad   = 0;

  logic [7:0]  ma [SZA];
  logic [7:0]  mb [SZB];
  logic [31:0] rda, rdb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit r, input bit w, input logic [31:0] ad,
                       input logic [1:0] ds, input bit sx, input logic [31:0] wd);
    if (sel) begin
      b_if.req = r; b_if.wr = w; b_if.addr = ad; b_if.dsize = ds; b_if.sext = sx; b_if.wdata = wd;
    end else begin
      a_if.req = r; a_if.wr = w; a_if.addr = ad; a_if.dsize = ds; a_if.sext = sx; a_if.wdata = wd;
    end
  endtask

  function automatic logic f_busy(input bit sel);
    return sel ? b_if.busy : a_if.busy;
  endfunction
  function automatic logic f_done(input bit sel);
    return sel ? b_if.done : a_if.done;
  endfunction
  function automatic logic f_err(input bit sel);
    return sel ? b_if.err : a_if.err;
  endfunction
  function automatic logic [31:0] f_rdata(input bit sel);
    return sel ? b_if.rdata : a_if.rdata;
  endfunction

  // Reference: applies one request to the byte arrays and returns expected err / rdata.
  task automatic model(input bit sel, input bit w, input logic [31:0] ad, input logic [1:0] ds,
                       input bit sx, input logic [31:0] wd, output bit e, output logic [31:0] rd);
    longint unsigned a64, sz;
    int nb;
    logic [31:0] v;
    a64 = ad;
    sz  = sel ? SZB : SZA;
    nb  = (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : 4;
    e   = (ds == 2'd3) || (nb == 2 && a64 % 2 != 0) || (nb == 4 && a64 % 4 != 0) || (a64 + nb > sz);
    if (!e) begin
      if (w) begin
        for (int i = 0; i < nb; i++) begin
          if (sel) mb[a64 + i] = 8'(wd >> (8 * (nb - 1 - i)));
          else     ma[a64 + i] = 8'(wd >> (8 * (nb - 1 - i)));
        end
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++)
          v = (v << 8) | 32'(sel ? mb[a64 + i] : ma[a64 + i]);
        if (sx && nb < 4 && v[8 * nb - 1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        if (sel) rdb = v;
        else     rda = v;
      end
    end
    rd = sel ? rdb : rda;
  endtask

  task automatic issue(input string tag, input bit sel, input bit w, input logic [31:0] ad,
                       input logic [1:0] ds, input bit sx, input logic [31:0] wd);
    bit e;
    logic [31:0] rd;
    int n, lat;
    lat = sel ? LTB : LTA;
    model(sel, w, ad, ds, sx, wd, e, rd);
    drive(sel, 1'b1, w, ad, ds, sx, wd);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 1'($urandom), $urandom, 2'($urandom), 1'($urandom), $urandom);
    chk({tag, "/busy"}, 32'(f_busy(sel)), 32'd1);
    n = 0;
    while (f_done(sel) !== 1'b1 && n < 12) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "/latency"}, 32'(n), 32'(lat));
    chk({tag, "/err"}, 32'(f_err(sel)), 32'(e));
    chk({tag, "/rdata"}, f_rdata(sel), rd);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "/done_width"}, 32'(f_done(sel)), 32'd0);
  endtask

  initial begin
    bit e;
    logic [31:0] rd, ad;
    logic [1:0] ds;
    int dn, seen;
    bit sel;

    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, 2'd0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, 2'd0, 1'b0, '0);
    rda = '0;
    rdb = '0;
    #12;
    chk("rst_a_busy", 32'(a_if.busy), 32'd0);
    chk("rst_a_done", 32'(a_if.done), 32'd0);
    chk("rst_a_err", 32'(a_if.err), 32'd0);
    chk("rst_a_rdata", a_if.rdata, 32'd0);
    chk("rst_b_busy", 32'(b_if.busy), 32'd0);
    chk("rst_b_done", 32'(b_if.done), 32'd0);
    chk("rst_b_err", 32'(b_if.err), 32'd0);
    chk("rst_b_rdata", b_if.rdata, 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    // Give every byte the random tests may read a defined value.
    for (int i = 0; i < 'h50; i += 4)   issue("init_a_lo", 1'b0, 1'b1, 32'(i), 2'd2, 1'b0, $urandom);
    for (int i = 'h1FB0; i < SZA; i += 4) issue("init_a_hi", 1'b0, 1'b1, 32'(i), 2'd2, 1'b0, $urandom);
    for (int i = 0; i < SZB; i += 4)    issue("init_b", 1'b1, 1'b1, 32'(i), 2'd2, 1'b0, $urandom);

    issue("st_w10", 1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'h12345678);
    issue("ld_w10", 1'b0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    chk("ld_w10_const", a_if.rdata, 32'h12345678);
    chk("mem10", 32'(dut_a.mem[32'h10]), 32'h12);
    chk("mem13", 32'(dut_a.mem[32'h13]), 32'h78);

    issue("st_h20", 1'b0, 1'b1, 32'h20, 2'd1, 1'b0, 32'h0000807F);
    issue("ld_b_sx", 1'b0, 1'b0, 32'h20, 2'd0, 1'b1, 32'h0);
    chk("ld_b_sx_const", a_if.rdata, 32'hFFFFFF80);
    issue("ld_b_zx", 1'b0, 1'b0, 32'h20, 2'd0, 1'b0, 32'h0);
    chk("ld_b_zx_const", a_if.rdata, 32'h00000080);
    issue("ld_h_sx", 1'b0, 1'b0, 32'h20, 2'd1, 1'b1, 32'h0);
    chk("ld_h_sx_const", a_if.rdata, 32'hFFFF807F);

    issue("err_w02", 1'b0, 1'b0, 32'h2, 2'd2, 1'b0, 32'h0);
    chk("err_w02_keep", a_if.rdata, 32'hFFFF807F);
    issue("err_h1fff", 1'b0, 1'b1, 32'h1FFF, 2'd1, 1'b0, 32'h0000A5A5);
    chk("err_h1fff_mem", 32'(dut_a.mem[32'h1FFF]), 32'(ma[32'h1FFF]));
    issue("st_w1ffc", 1'b0, 1'b1, 32'h1FFC, 2'd2, 1'b0, 32'hCAFEF00D);
    issue("ld_w1ffc", 1'b0, 1'b0, 32'h1FFC, 2'd2, 1'b0, 32'h0);
    chk("ld_w1ffc_const", a_if.rdata, 32'hCAFEF00D);
    issue("err_ds3", 1'b0, 1'b0, 32'h8, 2'd3, 1'b0, 32'h0);
    issue("err_wrap", 1'b0, 1'b0, 32'hFFFFFFFC, 2'd2, 1'b0, 32'h0);

    // req held high: only edges 0, 5 and 10 accept; busy-time requests are stores that must be dropped.
    dn = 0;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (b_if.done === 1'b1) dn++;
      if (k <= 14) chk("busy_edge", 32'(b_if.busy), (k == 0 || k == 5 || k == 10) ? 32'd0 : 32'd1);
      if (k == 0 || k == 5 || k == 10) begin
        model(1'b1, 1'b0, 32'(4 * (k / 5)), 2'd2, 1'b0, 32'h0, e, rd);
        drive(1'b1, 1'b1, 1'b0, 32'(4 * (k / 5)), 2'd2, 1'b0, 32'h0);
      end else if (k < 15) begin
        drive(1'b1, 1'b1, 1'b1, 32'($urandom_range(0, 31) * 4), 2'd2, 1'b0, $urandom);
      end else begin
        drive(1'b1, 1'b0, 1'b0, '0, 2'd0, 1'b0, '0);
      end
    end
    chk("busy_done_count", 32'(dn), 32'd3);
    chk("busy_rdata", b_if.rdata, rdb);

    // Reset two cycles into a store: nothing committed, no late done.
    seen = 0;
    drive(1'b1, 1'b1, 1'b1, 32'h40, 2'd2, 1'b0, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, '0, 2'd0, 1'b0, '0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_b = 1'b1;
    #1;
    chk("midrst_busy", 32'(b_if.busy), 32'd0);
    chk("midrst_done", 32'(b_if.done), 32'd0);
    chk("midrst_err", 32'(b_if.err), 32'd0);
    chk("midrst_rdata", b_if.rdata, 32'd0);
    rdb = '0;
    repeat (2) begin
      @(negedge clk);
      if (b_if.done === 1'b1) seen++;
    end
    rst_b = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (b_if.done === 1'b1) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    for (int i = 'h40; i < 'h44; i++) chk("midrst_mem", 32'(dut_b.mem[i]), 32'(mb[i]));

    for (int t = 0; t < 300; t++) begin
      sel = 1'($urandom);
      ds  = 2'($urandom);
      if (sel) begin
        ad = 32'($urandom_range(0, 'h83));
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: ad = 32'($urandom_range(0, 'h47));
          4, 5, 6, 7: ad = 32'h1FB8 + 32'($urandom_range(0, 'h47));
          8:          ad = $urandom | 32'h80000000;
          default:    ad = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        endcase
      end
      issue("rand", sel, 1'($urandom), ad, ds, 1'($urandom), $urandom);
    end

    for (int i = 0; i < 'h50; i++)      chk("final_mem_a_lo", 32'(dut_a.mem[i]), 32'(ma[i]));
    for (int i = 'h1FB0; i < SZA; i++)  chk("final_mem_a_hi", 32'(dut_a.mem[i]), 32'(ma[i]));
    for (int i = 0; i < SZB; i++)       chk("final_mem_b", 32'(dut_b.mem[i]), 32'(mb[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
